// File: rtl/lap_stopwatch_core_pkg.sv
// Shared types and constants for the lap stopwatch core.
package lap_stopwatch_core_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    REVIEW = 2'd3
  } state_t;

  localparam int unsigned SEC_MOD  = 60;
  localparam int unsigned DSEC_MOD = 10;

  // One stored time: min:sec:dsec, 17 bits.
  typedef struct packed {
    logic [6:0] min;
    logic [5:0] sec;
    logic [3:0] dsec;
  } lap_time_t;

endpackage

// File: rtl/counter.sv
// Modular up-counter with synchronous load; shared by the prescaler and the time digits.
module counter #(
  parameter int unsigned MODULUS = 10,
  parameter int unsigned W       = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         incr,
  input  logic         set_data,
  input  logic [W-1:0] data,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)           q <= '0;
    else if (set_data) q <= data;
    else if (incr)     q <= (q == W'(MODULUS - 1)) ? '0 : q + 1'b1;
  end

endmodule

// File: rtl/lap_stopwatch_core_lap_mem.sv
// Lap register file: one write port, two asynchronous read ports, synchronous clear.
module lap_mem
  import lap_stopwatch_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  lap_time_t     wdata,
  input  logic [AW-1:0] raddr_a,
  output lap_time_t     rdata_a,
  input  logic [AW-1:0] raddr_b,
  output lap_time_t     rdata_b
);

  lap_time_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/lap_stopwatch_core.sv
// Stopwatch core: min:sec:dsec time base, lap memory, pause/resume and lap review.
module lap_stopwatch_core
  import lap_stopwatch_core_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned MAX_LAPS = 4,
  parameter int unsigned MIN_MAX  = 99,
  localparam int unsigned LW      = $clog2(MAX_LAPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_stop,
  input  logic          lap,
  input  logic          show,
  output logic [3:0]    disp_dsec,
  output logic [5:0]    disp_sec,
  output logic [6:0]    disp_min,
  output logic [6:0]    last_min,
  output logic [5:0]    last_sec,
  output logic [LW-1:0] lap_count,
  output logic [LW-1:0] review_idx,
  output logic          running,
  output logic          lap_ovf,
  output logic          sat
);

  localparam int unsigned TICKS = CLK_FREQ / 10;
  localparam int unsigned PW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int unsigned AW    = (MAX_LAPS > 1) ? $clog2(MAX_LAPS) : 1;

  state_t state, state_next;

  logic [PW-1:0] pre_q;
  logic [3:0]    dsec_q;
  logic [5:0]    sec_q;
  logic [6:0]    min_q;
  logic          p_wrap, d_wrap, s_wrap, at_max, full;
  logic          cnt_en, clr_all, mem_we, ovf_set, sat_set;
  logic          ridx_first, ridx_inc, ridx_clr;
  lap_time_t     live, rev_entry, last_entry;

  assign live   = '{min: min_q, sec: sec_q, dsec: dsec_q};
  assign full   = (lap_count == LW'(MAX_LAPS));
  assign at_max = (min_q == 7'(MIN_MAX)) && (sec_q == 6'(SEC_MOD - 1)) &&
                  (dsec_q == 4'(DSEC_MOD - 1));

  // Carry chain: each stage advances only on the wrap of the stage below.
  assign p_wrap = cnt_en && (pre_q == PW'(TICKS - 1));
  assign d_wrap = p_wrap && (dsec_q == 4'(DSEC_MOD - 1));
  assign s_wrap = d_wrap && (sec_q == 6'(SEC_MOD - 1));

  counter #(.MODULUS(TICKS),       .W(PW)) u_pre  (.clk(clk), .rst(rst), .incr(cnt_en), .set_data(clr_all), .data('0), .q(pre_q));
  counter #(.MODULUS(DSEC_MOD),    .W(4))  u_dsec (.clk(clk), .rst(rst), .incr(p_wrap), .set_data(clr_all), .data('0), .q(dsec_q));
  counter #(.MODULUS(SEC_MOD),     .W(6))  u_sec  (.clk(clk), .rst(rst), .incr(d_wrap), .set_data(clr_all), .data('0), .q(sec_q));
  counter #(.MODULUS(MIN_MAX + 1), .W(7))  u_min  (.clk(clk), .rst(rst), .incr(s_wrap), .set_data(clr_all), .data('0), .q(min_q));

  lap_mem #(.DEPTH(MAX_LAPS), .AW(AW)) u_mem (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_all),
    .we     (mem_we),
    .waddr  (AW'(lap_count)),
    .wdata  (live),
    .raddr_a(AW'(review_idx - 1'b1)),
    .rdata_a(rev_entry),
    .raddr_b(AW'(lap_count - 1'b1)),
    .rdata_b(last_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Pulse priority start_stop > lap > show: a higher pulse swallows the others even when ignored.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (start_stop) state_next = RUN;
      RUN:    if (at_max || start_stop) state_next = PAUSE;
      PAUSE:  begin
        if (start_stop) begin
          if (!sat) state_next = RUN;
        end else if (lap) state_next = IDLE;
        else if (show && lap_count != '0) state_next = REVIEW;
      end
      REVIEW: begin
        if (start_stop) state_next = REVIEW;
        else if (lap) state_next = PAUSE;
        else if (show && review_idx == lap_count) state_next = PAUSE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_en     = 1'b0;
    clr_all    = 1'b0;
    mem_we     = 1'b0;
    ovf_set    = 1'b0;
    sat_set    = 1'b0;
    ridx_first = 1'b0;
    ridx_inc   = 1'b0;
    ridx_clr   = 1'b0;
    unique case (state)
      RUN: begin
        if (at_max) sat_set = 1'b1;
        else if (!start_stop) begin
          cnt_en = 1'b1;
          if (lap) begin
            if (full) ovf_set = 1'b1;
            else      mem_we  = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (!start_stop && lap) clr_all = 1'b1;
        else if (!start_stop && show && lap_count != '0) ridx_first = 1'b1;
      end
      REVIEW: begin
        if (!start_stop) begin
          if (lap) ridx_clr = 1'b1;
          else if (show) begin
            if (review_idx == lap_count) ridx_clr = 1'b1;
            else                         ridx_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      lap_count  <= '0;
      review_idx <= '0;
      lap_ovf    <= 1'b0;
      sat        <= 1'b0;
    end else begin
      if (mem_we)     lap_count  <= lap_count + 1'b1;
      if (ovf_set)    lap_ovf    <= 1'b1;
      if (sat_set)    sat        <= 1'b1;
      if (ridx_first) review_idx <= LW'(1);
      if (ridx_inc)   review_idx <= review_idx + 1'b1;
      if (ridx_clr)   review_idx <= '0;
    end
  end

  assign running   = (state == RUN);
  assign disp_dsec = (state == REVIEW) ? rev_entry.dsec : dsec_q;
  assign disp_sec  = (state == REVIEW) ? rev_entry.sec  : sec_q;
  assign disp_min  = (state == REVIEW) ? rev_entry.min  : min_q;
  assign last_min  = (lap_count == '0) ? '0 : last_entry.min;
  assign last_sec  = (lap_count == '0) ? '0 : last_entry.sec;

endmodule
